// File: rtl/fast_adder_pkg.sv
// Shared constants for the registered carry-lookahead adder.
package fast_adder_pkg;

  // Operand width and lookahead group size.
  localparam int WIDTH      = 32;
  localparam int GROUP      = 4;

  // Number of 4-bit lookahead groups in a full-width operand.
  localparam int NUM_GROUPS = WIDTH / GROUP;

endpackage : fast_adder_pkg

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: local sum plus group generate/propagate
// for the second-level lookahead in the top level.
module cla_group4
  import fast_adder_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] bit_g;
  logic [GROUP-1:0] bit_p;
  logic [GROUP-1:0] carry;

  // Per-bit terms, in-group carries flattened from cin, and group G/P.
  // G/P never depend on cin, so the top-level lookahead has no path back
  // through the sum logic.
  always_comb begin
    bit_g = a & b;
    bit_p = a ^ b;

    carry[0] = cin;
    carry[1] = bit_g[0] | (bit_p[0] & cin);
    carry[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & cin);
    carry[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
             | (bit_p[2] & bit_p[1] & bit_p[0] & cin);

    sum = bit_p ^ carry;

    g = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
      | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
    p = &bit_p;
  end

endmodule : cla_group4

// File: rtl/fast_adder_32bit.sv
// Registered two-level carry-lookahead adder: {C, S} = A + B + Cin, with
// carry-out and two's-complement overflow, one-cycle latency.
module fast_adder_32bit
  import fast_adder_pkg::*;
#(
  parameter int WIDTH = fast_adder_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             overflow,
  output logic             out_valid
);

  localparam int NGRP = WIDTH / GROUP;

  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] sum_next;
  logic             ovf_next;

  logic [WIDTH-1:0] s_reg;
  logic             c_reg;
  logic             ovf_reg;
  logic             valid_reg;

  // First level: one 4-bit lookahead group per nibble.
  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_group
      cla_group4 u_group (
        .a   (A[gi*GROUP +: GROUP]),
        .b   (B[gi*GROUP +: GROUP]),
        .cin (grp_c[gi]),
        .sum (sum_next[gi*GROUP +: GROUP]),
        .g   (grp_g[gi]),
        .p   (grp_p[gi])
      );
    end
  endgenerate

  // Second level: every group carry-in is a flat sum of products over the
  // group G/P pairs and Cin, so no carry ripples from group to group.
  always_comb begin
    logic acc;
    logic prop;
    acc      = 1'b0;
    prop     = 1'b1;
    grp_c    = '0;
    grp_c[0] = Cin;
    for (int k = 0; k < NGRP; k++) begin
      prop = 1'b1;
      for (int m = 0; m <= k; m++) prop = prop & grp_p[m];
      acc = Cin & prop;
      for (int j = 0; j <= k; j++) begin
        prop = 1'b1;
        for (int m = j + 1; m <= k; m++) prop = prop & grp_p[m];
        acc = acc | (grp_g[j] & prop);
      end
      grp_c[k+1] = acc;
    end
  end

  // Signed overflow: like-signed operands giving a result of the other sign
  // (equivalent to c[31] ^ c[32], without exporting an in-group carry).
  assign ovf_next = (A[WIDTH-1] == B[WIDTH-1]) & (sum_next[WIDTH-1] != A[WIDTH-1]);

  // Output registers: capture on in_valid, hold otherwise; reset wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_reg     <= '0;
      c_reg     <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        s_reg   <= sum_next;
        c_reg   <= grp_c[NGRP];
        ovf_reg <= ovf_next;
      end
    end
  end

  assign S         = s_reg;
  assign C         = c_reg;
  assign overflow  = ovf_reg;
  assign out_valid = valid_reg;

endmodule : fast_adder_32bit

// File: tb/tb_fast_adder_32bit.sv
// Self-checking bench for fast_adder_32bit: arithmetic reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_fast_adder_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [31:0] S;
  logic        C;
  logic        overflow;
  logic        out_valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Reference state
  logic [31:0] m_s;
  logic        m_c;
  logic        m_o;
  logic        m_v;

  fast_adder_32bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .S         (S),
    .C         (C),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: unsigned 33-bit sum and a signed range test.
  always @(posedge clk) begin
    logic [32:0] usum;
    longint      ssum;
    if (!rst_n) begin
      m_s <= '0; m_c <= 1'b0; m_o <= 1'b0; m_v <= 1'b0;
    end else begin
      m_v <= in_valid;
      if (in_valid) begin
        usum = {1'b0, A} + {1'b0, B} + {32'd0, Cin};
        ssum = longint'($signed(A)) + longint'($signed(B)) + longint'(Cin);
        m_s <= usum[31:0];
        m_c <= usum[32];
        m_o <= (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_valid", {31'd0, out_valid}, {31'd0, m_v});
      check("model_S",     S,                  m_s);
      check("model_C",     {31'd0, C},         {31'd0, m_c});
      check("model_ovf",   {31'd0, overflow},  {31'd0, m_o});
    end
  end

  // Present one operand set, clock it in, then check literal expectations.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                    input logic [31:0] es, input logic ec, input logic eo, input string name);
    A = a; B = b; Cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    check({name, "_S"},   S,                 es);
    check({name, "_C"},   {31'd0, C},        {31'd0, ec});
    check({name, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    check({name, "_vld"}, {31'd0, out_valid}, 32'd1);
    $display("op %s: A=%08h B=%08h Cin=%0d -> S=%08h C=%0d ovf=%0d", name, a, b, ci, S, C, overflow);
  endtask

  initial begin
    // Reset with an operation presented: it must be discarded.
    rst_n = 1'b0; in_valid = 1'b1; A = 32'hFFFF_FFFF; B = 32'h1; Cin = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b1;
    check("rst_S",   S,                  32'h0);
    check("rst_C",   {31'd0, C},         32'd0);
    check("rst_ovf", {31'd0, overflow},  32'd0);
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_vld", {31'd0, out_valid}, 32'd0);

    op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "uwrap");
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "posovf");
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "negovf");
    op(32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0, "cin_grp");
    op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "cin_full");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "all_ones");

    // Streaming: three back-to-back operations.
    op(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, "str1");
    op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "str2");
    op(32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "str3");

    // Drop in_valid with changing operands: outputs hold, out_valid low.
    in_valid = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_0000; Cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("hold_vld", {31'd0, out_valid}, 32'd0);
      check("hold_S",   S,                  32'h0);
      check("hold_C",   {31'd0, C},         32'd1);
      $display("hold %0d: S=%08h C=%0d vld=%0d", i, S, C, out_valid);
    end

    // Random operations with occasional idle cycles, checked by the model.
    for (int i = 0; i < 10000; i++) begin
      A = $urandom; B = $urandom; Cin = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 7) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    $display("random phase done");

    // Reset mid-stream clears everything.
    rst_n = 1'b0; in_valid = 1'b1; A = 32'h7FFF_FFFF; B = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    check("rst2_S",   S,                  32'h0);
    check("rst2_vld", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fast_adder_32bit
